// File: rtl/free_addr_return.sv
// ---------------------------------------------------------------------------
// free_addr_return
//
// Write-side companion of the switch's free-address FIFO. Collects buffer
// addresses released by PORT_NUM output ports into one holding register per
// port. It picks one holding register per cycle by round-robin and writes
// that address back into the free-list FIFO. When the FIFO is full, it
// applies back-pressure to the ports.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous reset, active-high
//   rel_valid     [PORT_NUM]        port i presents a released address
//   rel_addr      [PORT_NUM*ADDR_W] port i address at [i*ADDR_W +: ADDR_W]
//   rel_ready     [PORT_NUM]        port i may hand over an address
//   fifo_full     free-list FIFO full
//   fifo_wr_err   FIFO reports write while full
//   fifo_wr_en    write strobe to the FIFO
//   fifo_wr_data  [ADDR_W] address written to the FIFO (0 when idle)
//   ret_cnt       [CNT_W]  total addresses written, wrapping
//   ovf_err       sticky: fifo_wr_err seen since reset
//
// Optional feature, macro FREE_DUP_CHK_EN (default: undefined)
//   alloc_valid / alloc_addr mirror FIFO reads and clear the matching bit in
//   a free-address bitmap. A released address is dropped if any of the
//   following holds:
//     - the address is already marked free;
//     - a lower-index port hands over the same address in the same cycle.
//   A dropped address is not loaded, and dup_err pulses one cycle later.
// ---------------------------------------------------------------------------
module free_addr_return #(
  parameter int ADDR_W   = 6,
  parameter int PORT_NUM = 4,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PORT_NUM-1:0]        rel_valid,
  input  logic [PORT_NUM*ADDR_W-1:0] rel_addr,
  output logic [PORT_NUM-1:0]        rel_ready,
  input  logic                       fifo_full,
  input  logic                       fifo_wr_err,
  output logic                       fifo_wr_en,
  output logic [ADDR_W-1:0]          fifo_wr_data,
  output logic [CNT_W-1:0]           ret_cnt,
  output logic                       ovf_err
`ifdef FREE_DUP_CHK_EN
  ,
  input  logic                       alloc_valid,
  input  logic [ADDR_W-1:0]          alloc_addr,
  output logic                       dup_err
`endif
);

  localparam int PTR_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam int DEPTH = 1 << ADDR_W;

  logic [PORT_NUM-1:0] hold_vld_q, hold_vld_d;
  logic [ADDR_W-1:0]   hold_addr_q [PORT_NUM];
  logic [ADDR_W-1:0]   hold_addr_d [PORT_NUM];
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    ret_cnt_q, ret_cnt_d;
  logic                ovf_q, ovf_d;

  logic [PORT_NUM-1:0] grant;
  logic [PTR_W-1:0]    grant_idx;
  logic                found;
  logic [PTR_W:0]      sum;
  logic [PTR_W-1:0]    idx;
  logic [PORT_NUM-1:0] accept;
  logic [PORT_NUM-1:0] drop;
  logic [PORT_NUM-1:0] load;

  // Round-robin search over the holding registers, starting at the pointer.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < PORT_NUM; k++) begin
      sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(PORT_NUM)) begin
        sum = sum - (PTR_W+1)'(PORT_NUM);
      end
      idx = sum[PTR_W-1:0];
      if (!found && hold_vld_q[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  assign fifo_wr_en   = (|hold_vld_q) & ~fifo_full;
  assign fifo_wr_data = fifo_wr_en ? hold_addr_q[grant_idx] : '0;

  // A register being drained this cycle can be refilled on the same edge.
  assign rel_ready = ~hold_vld_q | ({PORT_NUM{fifo_wr_en}} & grant);
  assign accept    = rel_valid & rel_ready;
  assign load      = accept & ~drop;

  always_comb begin
    hold_vld_d = hold_vld_q;
    if (fifo_wr_en) begin
      hold_vld_d = hold_vld_d & ~grant;
    end
    hold_vld_d = hold_vld_d | load;
    for (int i = 0; i < PORT_NUM; i++) begin
      hold_addr_d[i] = load[i] ? rel_addr[i*ADDR_W +: ADDR_W] : hold_addr_q[i];
    end
    ptr_d     = ptr_q;
    ret_cnt_d = ret_cnt_q;
    if (fifo_wr_en) begin
      ptr_d     = (grant_idx == PTR_W'(PORT_NUM-1)) ? '0 : grant_idx + 1'b1;
      ret_cnt_d = ret_cnt_q + 1'b1;
    end
    ovf_d = ovf_q | fifo_wr_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld_q <= '0;
      for (int i = 0; i < PORT_NUM; i++) begin
        hold_addr_q[i] <= '0;
      end
      ptr_q     <= '0;
      ret_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      hold_vld_q <= hold_vld_d;
      for (int i = 0; i < PORT_NUM; i++) begin
        hold_addr_q[i] <= hold_addr_d[i];
      end
      ptr_q     <= ptr_d;
      ret_cnt_q <= ret_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  assign ret_cnt = ret_cnt_q;
  assign ovf_err = ovf_q;

`ifdef FREE_DUP_CHK_EN
  logic [DEPTH-1:0]  free_map_q, free_map_d;
  logic              dup_q, dup_d;
  logic [ADDR_W-1:0] a_i;
  logic              dup_hit;

  // Drop decisions use the bitmap as it stood at the start of the cycle.
  // Among ports carrying the same address, the lowest index wins.
  // Sets are applied after the allocator clear, so a same-cycle set wins.
  always_comb begin
    drop       = '0;
    a_i        = '0;
    dup_hit    = 1'b0;
    free_map_d = free_map_q;
    if (alloc_valid) begin
      free_map_d[alloc_addr] = 1'b0;
    end
    for (int i = 0; i < PORT_NUM; i++) begin
      a_i     = rel_addr[i*ADDR_W +: ADDR_W];
      dup_hit = free_map_q[a_i];
      for (int j = 0; j < PORT_NUM; j++) begin
        if (j < i && accept[j] && rel_addr[j*ADDR_W +: ADDR_W] == a_i) begin
          dup_hit = 1'b1;
        end
      end
      drop[i] = accept[i] & dup_hit;
      if (accept[i] && !dup_hit) begin
        free_map_d[a_i] = 1'b1;
      end
    end
    dup_d = |drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      free_map_q <= '1;
      dup_q      <= 1'b0;
    end else begin
      free_map_q <= free_map_d;
      dup_q      <= dup_d;
    end
  end

  assign dup_err = dup_q;
`else
  assign drop = '0;
`endif

endmodule

// File: tb/tb_free_addr_return.sv
module tb_free_addr_return;
  localparam int ADDR_W = 6;
  localparam int N      = 4;
  localparam int CNT_W  = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         rel_valid;
  logic [N*ADDR_W-1:0]  rel_addr;
  logic [N-1:0]         rel_ready;
  logic                 fifo_full;
  logic                 fifo_wr_err;
  logic                 fifo_wr_en;
  logic [ADDR_W-1:0]    fifo_wr_data;
  logic [CNT_W-1:0]     ret_cnt;
  logic                 ovf_err;
`ifdef FREE_DUP_CHK_EN
  logic                 alloc_valid;
  logic [ADDR_W-1:0]    alloc_addr;
  logic                 dup_err;
`endif

  always #5 clk = ~clk;

  free_addr_return #(.ADDR_W(ADDR_W), .PORT_NUM(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rel_valid(rel_valid), .rel_addr(rel_addr), .rel_ready(rel_ready),
    .fifo_full(fifo_full), .fifo_wr_err(fifo_wr_err),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .ret_cnt(ret_cnt), .ovf_err(ovf_err)
`ifdef FREE_DUP_CHK_EN
    , .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .dup_err(dup_err)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: pending address per port, round-robin start, counters.
  bit               pend  [N];
  logic [ADDR_W-1:0] paddr [N];
  int               rr;
  int               cnt;
  bit               ovf;
`ifdef FREE_DUP_CHK_EN
  bit               fmap [DEPTH];
  bit               dup_pend;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      pend[i]  = 0;
      paddr[i] = '0;
    end
    rr  = 0;
    cnt = 0;
    ovf = 0;
`ifdef FREE_DUP_CHK_EN
    for (int a = 0; a < DEPTH; a++) fmap[a] = 1;
    dup_pend = 0;
`endif
  endtask

  // One clock cycle: check outputs mid-cycle against the model, then advance
  // the model with the inputs that the DUT sees at the coming edge.
  task automatic tick();
    bit wr;
    bit any;
    int g;
    int p;
    logic [N-1:0] rdy;
    logic [N-1:0] acc;
    logic [ADDR_W-1:0] ai;
    logic [ADDR_W-1:0] aj;
    bit dropv [N];
    #4;
    any = 0;
    g   = 0;
    for (int k = 0; k < N; k++) begin
      p = (rr + k) % N;
      if (!any && pend[p]) begin
        any = 1;
        g   = p;
      end
    end
    wr = any && !fifo_full;
    for (int i = 0; i < N; i++) rdy[i] = !pend[i] || (wr && g == i);
    chk("rel_ready", 32'(rel_ready), 32'(rdy));
    chk("wr_en", 32'(fifo_wr_en), 32'(wr));
    chk("wr_data", 32'(fifo_wr_data), wr ? 32'(paddr[g]) : 32'd0);
    chk("ret_cnt", 32'(ret_cnt), 32'(cnt % (1 << CNT_W)));
    chk("ovf_err", 32'(ovf_err), 32'(ovf));
`ifdef FREE_DUP_CHK_EN
    chk("dup_err", 32'(dup_err), 32'(dup_pend));
`endif
    if (rst) begin
      model_reset();
    end else begin
      acc = rel_valid & rdy;
      for (int i = 0; i < N; i++) dropv[i] = 0;
`ifdef FREE_DUP_CHK_EN
      dup_pend = 0;
      for (int i = 0; i < N; i++) begin
        ai = rel_addr[i*ADDR_W +: ADDR_W];
        if (acc[i]) begin
          if (fmap[ai]) dropv[i] = 1;
          for (int j = 0; j < i; j++) begin
            aj = rel_addr[j*ADDR_W +: ADDR_W];
            if (acc[j] && aj == ai) dropv[i] = 1;
          end
        end
        if (dropv[i]) dup_pend = 1;
      end
      if (alloc_valid) fmap[alloc_addr] = 0;
      for (int i = 0; i < N; i++) begin
        ai = rel_addr[i*ADDR_W +: ADDR_W];
        if (acc[i] && !dropv[i]) fmap[ai] = 1;
      end
`endif
      if (wr) begin
        pend[g] = 0;
        rr  = (g + 1) % N;
        cnt = cnt + 1;
      end
      for (int i = 0; i < N; i++) begin
        if (acc[i] && !dropv[i]) begin
          pend[i]  = 1;
          paddr[i] = rel_addr[i*ADDR_W +: ADDR_W];
        end
      end
      if (fifo_wr_err) ovf = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit drain);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
`ifdef FREE_DUP_CHK_EN
    // Mark every address as handed out so releases are legal afterwards.
    if (drain) begin
      for (int a = 0; a < DEPTH; a++) begin
        alloc_valid = 1'b1;
        alloc_addr  = ADDR_W'(a);
        tick();
      end
      alloc_valid = 1'b0;
    end
`else
    if (drain) tick();
`endif
  endtask

  initial begin
    rst         = 1'b1;
    rel_valid   = '0;
    rel_addr    = '0;
    fifo_full   = 1'b0;
    fifo_wr_err = 1'b0;
`ifdef FREE_DUP_CHK_EN
    alloc_valid = 1'b0;
    alloc_addr  = '0;
`endif
    @(posedge clk);
    #1;
    model_reset();

    // Reset with all ports requesting.
    rel_valid = 4'b1111;
    for (int i = 0; i < N; i++) rel_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(8 + i);
    tick();
    tick();
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_ret_cnt", 32'(ret_cnt), 32'd0);
    chk("rst_ovf", 32'(ovf_err), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(rel_ready), 32'hF);
    rel_valid = '0;
    tick();
    tick();

    // Single port, back-to-back.
    do_reset(1);
    rel_valid = 4'b0100;
    for (int v = 5; v <= 7; v++) begin
      rel_addr[2*ADDR_W +: ADDR_W] = ADDR_W'(v);
      tick();
      chk("sp_data", 32'(fifo_wr_data), 32'(v));
      chk("sp_ready2", 32'(rel_ready[2]), 32'd1);
    end
    rel_valid = '0;
    tick();
    tick();
    chk("sp_cnt", 32'(ret_cnt), 32'd3);

    // Round-robin with every port valid.
    do_reset(0);
    rel_valid = 4'b1111;
    for (int i = 0; i < N; i++) rel_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(8'h10 + i);
    for (int k = 1; k <= 9; k++) begin
      tick();
`ifndef FREE_DUP_CHK_EN
      if (k <= 8) chk("rr_data", 32'(fifo_wr_data), 32'(8'h10 + (k - 1) % 4));
`endif
    end
`ifndef FREE_DUP_CHK_EN
    chk("rr_cnt", 32'(ret_cnt), 32'd8);
`endif
    rel_valid = '0;
    for (int k = 0; k < 5; k++) tick();

    // Back-pressure: two loaded ports held while the FIFO is full.
    do_reset(1);
    fifo_full = 1'b1;
    rel_valid = 4'b0011;
    rel_addr[0 +: ADDR_W]      = 6'h21;
    rel_addr[ADDR_W +: ADDR_W] = 6'h22;
    tick();
    rel_addr[0 +: ADDR_W]      = 6'h31;
    rel_addr[ADDR_W +: ADDR_W] = 6'h32;
    for (int k = 0; k < 5; k++) begin
      chk("bp_ready", 32'(rel_ready[1:0]), 32'd0);
      chk("bp_wr_en", 32'(fifo_wr_en), 32'd0);
      tick();
    end
    rel_valid = '0;
    fifo_full = 1'b0;
    #1;
    chk("bp_first", 32'(fifo_wr_data), 32'h21);
    tick();
    chk("bp_second", 32'(fifo_wr_data), 32'h22);
    tick();
    chk("bp_idle", 32'(fifo_wr_en), 32'd0);
    chk("bp_cnt", 32'(ret_cnt), 32'd2);

    // Sticky overflow flag.
    fifo_wr_err = 1'b1;
    tick();
    fifo_wr_err = 1'b0;
    chk("ovf_set", 32'(ovf_err), 32'd1);
    for (int k = 0; k < 3; k++) tick();
    chk("ovf_hold", 32'(ovf_err), 32'd1);
    do_reset(0);
    chk("ovf_clr", 32'(ovf_err), 32'd0);

`ifdef FREE_DUP_CHK_EN
    // Releasing an address that is still free is dropped.
    rel_valid = 4'b0001;
    rel_addr[0 +: ADDR_W] = 6'h03;
    tick();
    rel_valid = '0;
    chk("dup_free_err", 32'(dup_err), 32'd1);
    chk("dup_free_wr", 32'(fifo_wr_en), 32'd0);
    tick();
    chk("dup_pulse", 32'(dup_err), 32'd0);
    alloc_valid = 1'b1;
    alloc_addr  = 6'h03;
    tick();
    alloc_valid = 1'b0;
    rel_valid = 4'b0001;
    tick();
    rel_valid = '0;
    chk("dup_ok_err", 32'(dup_err), 32'd0);
    chk("dup_ok_data", 32'(fifo_wr_data), 32'h03);
    tick();
    // Same address on ports 0 and 1 in one cycle.
    alloc_valid = 1'b1;
    alloc_addr  = 6'h09;
    tick();
    alloc_valid = 1'b0;
    rel_valid = 4'b0011;
    rel_addr[0 +: ADDR_W]      = 6'h09;
    rel_addr[ADDR_W +: ADDR_W] = 6'h09;
    tick();
    rel_valid = '0;
    chk("dup_same_err", 32'(dup_err), 32'd1);
    chk("dup_same_data", 32'(fifo_wr_data), 32'h09);
    tick();
    chk("dup_same_once", 32'(fifo_wr_en), 32'd0);
    tick();
`endif

    // Randomised traffic against the model.
    do_reset(1);
    for (int k = 0; k < 400; k++) begin
      rst         = ($urandom % 150) == 0;
      rel_valid   = N'($urandom);
      rel_addr    = (N*ADDR_W)'($urandom);
      fifo_full   = ($urandom % 4) == 0;
      fifo_wr_err = ($urandom % 64) == 0;
`ifdef FREE_DUP_CHK_EN
      alloc_valid = ($urandom % 2) == 0;
      alloc_addr  = ADDR_W'($urandom);
`endif
      tick();
    end
    rst = 1'b0;
    rel_valid = '0;
    fifo_full = 1'b0;
    fifo_wr_err = 1'b0;
    for (int k = 0; k < 6; k++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
